// File: rtl/directory_arbiter.sv
// directory_arbiter
//   Arbitrates four requesters onto a directory covering four memory blocks.
//   It runs one coherence transaction at a time: look up the block, send an
//   invalidate or fetch message if needed, collect acks, then reply.
//
// Ports
//   clock        single clock, all state changes on posedge
//   reset        synchronous, active-high
//   req[3:0]     per-requester request valid
//   req_op[7:0]  2 bits per requester: 00 read miss, 01 read hit,
//                10 data writeback, 11 write miss
//   req_blk[7:0] 2 bits per requester: target block index
//   ack[3:0]     per-processor acknowledge of an invalidate/fetch message
//   grant[3:0]   one-hot accepted requester (one cycle, in LOOKUP)
//   msg_valid    coherence message strobe (one cycle, in SEND)
//   msg_type     01 invalidate, 10 fetch, 11 fetch-invalidate, 00 none
//   msg_dst      destination bitmask of the message
//   reply_valid  data value reply strobe (one cycle, in REPLY)
//   reply_dst    one-hot reply destination
//   proto_err    one-cycle pulse on an illegal writeback
//   busy         high whenever the FSM is not IDLE
//   fsm_state    current FSM state, for debug and checkers
//
// Handshake: a requester raises req with its op/blk and holds all three
// steady until it sees its grant bit; grant is the acceptance, after which
// req may drop. There is no back-pressure on msg/reply strobes. ack is
// sampled every cycle in SEND and WAIT_ACK; only bits still pending count.
module directory_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [7:0] req_op,
  input  logic [7:0] req_blk,
  input  logic [3:0] ack,
  output logic [3:0] grant,
  output logic       msg_valid,
  output logic [1:0] msg_type,
  output logic [3:0] msg_dst,
  output logic       reply_valid,
  output logic [3:0] reply_dst,
  output logic       proto_err,
  output logic       busy,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_SEND     = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_REPLY    = 3'd4
  } state_t;

  localparam logic [1:0] OP_RHIT   = 2'b01;
  localparam logic [1:0] OP_WB     = 2'b10;
  localparam logic [1:0] OP_WMISS  = 2'b11;
  localparam logic [1:0] DIR_U     = 2'b00;
  localparam logic [1:0] DIR_S     = 2'b01;
  localparam logic [1:0] DIR_E     = 2'b10;
  localparam logic [1:0] MSG_NONE  = 2'b00;
  localparam logic [1:0] MSG_INV   = 2'b01;
  localparam logic [1:0] MSG_FETCH = 2'b10;
  localparam logic [1:0] MSG_FINV  = 2'b11;

  state_t     state, next_state;
  logic [1:0] last_winner, win, cand;
  logic [1:0] cur_id, cur_op, cur_blk;
  logic [3:0] pend, pend_next;
  logic [1:0] kind, lk_kind;
  logic [1:0] cmt_st, lk_st;
  logic [3:0] cmt_sh, lk_sh;
  logic       wb_commit;
  logic [1:0] dir_st [4];
  logic [3:0] dir_sh [4];
  logic [3:0] pbit, cur_sh;
  logic [1:0] cur_st;
  logic       is_write;
  logic [3:0] grant_c, msg_dst_c, reply_dst_c;
  logic       msg_valid_c, reply_valid_c, err_c;
  logic [1:0] msg_type_c;

  // Round-robin: scan offsets 4..1 so the smallest offset past last_winner
  // overwrites the others; offset 4 wraps back to last_winner itself.
  always_comb begin
    win  = last_winner;
    cand = '0;
    for (int i = 4; i >= 1; i--) begin
      cand = last_winner + 2'(i);
      if (req[cand]) win = cand;
    end
  end

  assign pbit     = 4'b0001 << cur_id;
  assign cur_st   = dir_st[cur_blk];
  assign cur_sh   = dir_sh[cur_blk];
  assign is_write = (cur_op == OP_WMISS);

  always_comb begin
    next_state    = state;
    pend_next     = pend;
    grant_c       = '0;
    msg_valid_c   = 1'b0;
    msg_type_c    = MSG_NONE;
    msg_dst_c     = '0;
    reply_valid_c = 1'b0;
    reply_dst_c   = '0;
    err_c         = 1'b0;
    lk_st         = cur_st;
    lk_sh         = cur_sh;
    lk_kind       = MSG_NONE;
    wb_commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req) next_state = S_LOOKUP;
      end
      S_LOOKUP: begin
        grant_c   = pbit;
        pend_next = '0;
        if (cur_op == OP_RHIT) begin
          next_state = S_IDLE;
        end else if (cur_op == OP_WB) begin
          next_state = S_IDLE;
          if (cur_st == DIR_E && cur_sh == pbit) begin
            wb_commit = 1'b1;
            lk_st     = DIR_U;
            lk_sh     = '0;
          end else begin
            err_c = 1'b1;
          end
        end else begin
          // Read or write miss. The commit values are held until REPLY so
          // that an aborted transaction leaves the directory untouched.
          next_state = S_REPLY;
          case (cur_st)
            DIR_S: begin
              if (is_write) begin
                lk_st     = DIR_E;
                lk_sh     = pbit;
                pend_next = cur_sh & ~pbit;
                if (pend_next != 4'b0) begin
                  lk_kind    = MSG_INV;
                  next_state = S_SEND;
                end
              end else begin
                lk_sh = cur_sh | pbit;
              end
            end
            DIR_E: begin
              // Owner missing on its own line needs nothing changed.
              if (cur_sh != pbit) begin
                pend_next  = cur_sh;
                next_state = S_SEND;
                if (is_write) begin
                  lk_kind = MSG_FINV;
                  lk_sh   = pbit;
                end else begin
                  lk_kind = MSG_FETCH;
                  lk_st   = DIR_S;
                  lk_sh   = cur_sh | pbit;
                end
              end
            end
            default: begin
              lk_st = is_write ? DIR_E : DIR_S;
              lk_sh = pbit;
            end
          endcase
        end
      end
      S_SEND: begin
        msg_valid_c = 1'b1;
        msg_type_c  = kind;
        msg_dst_c   = pend;
        pend_next   = pend & ~ack;
        next_state  = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        pend_next = pend & ~ack;
        if (pend_next == 4'b0) next_state = S_REPLY;
      end
      S_REPLY: begin
        reply_valid_c = 1'b1;
        reply_dst_c   = pbit;
        next_state    = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      last_winner <= 2'd3;
      pend        <= '0;
      cur_id      <= '0;
      cur_op      <= '0;
      cur_blk     <= '0;
      kind        <= MSG_NONE;
      cmt_st      <= DIR_U;
      cmt_sh      <= '0;
      for (int b = 0; b < 4; b++) begin
        dir_st[b] <= DIR_U;
        dir_sh[b] <= '0;
      end
    end else begin
      state <= next_state;
      pend  <= pend_next;
      if (state == S_IDLE && |req) begin
        cur_id      <= win;
        cur_op      <= req_op[{win, 1'b0} +: 2];
        cur_blk     <= req_blk[{win, 1'b0} +: 2];
        last_winner <= win;
      end
      if (state == S_LOOKUP) begin
        cmt_st <= lk_st;
        cmt_sh <= lk_sh;
        kind   <= lk_kind;
        if (wb_commit) begin
          dir_st[cur_blk] <= lk_st;
          dir_sh[cur_blk] <= lk_sh;
        end
      end
      if (state == S_REPLY) begin
        dir_st[cur_blk] <= cmt_st;
        dir_sh[cur_blk] <= cmt_sh;
      end
    end
  end

  // Outputs are forced low while reset is held so nothing leaks out of an
  // aborted transaction during the reset cycle itself.
  assign grant       = reset ? 4'b0 : grant_c;
  assign msg_valid   = reset ? 1'b0 : msg_valid_c;
  assign msg_type    = reset ? 2'b0 : msg_type_c;
  assign msg_dst     = reset ? 4'b0 : msg_dst_c;
  assign reply_valid = reset ? 1'b0 : reply_valid_c;
  assign reply_dst   = reset ? 4'b0 : reply_dst_c;
  assign proto_err   = reset ? 1'b0 : err_c;
  assign busy        = reset ? 1'b0 : (state != S_IDLE);
  assign fsm_state   = reset ? 3'd0 : state;

endmodule

// File: tb/tb_directory_arbiter.sv
// tb_directory_arbiter
//   Directed and randomized transactions against directory_arbiter. A
//   transaction-level model (per-block state and sharer set, round-robin
//   pointer) predicts grants, messages, replies and directory contents.
module tb_directory_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] req_op = '0;
  logic [7:0] req_blk = '0;
  logic [3:0] ack = '0;
  logic [3:0] grant;
  logic       msg_valid;
  logic [1:0] msg_type;
  logic [3:0] msg_dst;
  logic       reply_valid;
  logic [3:0] reply_dst;
  logic       proto_err;
  logic       busy;
  logic [2:0] fsm_state;

  directory_arbiter dut (
    .clock(clock), .reset(reset), .req(req), .req_op(req_op),
    .req_blk(req_blk), .ack(ack), .grant(grant), .msg_valid(msg_valid),
    .msg_type(msg_type), .msg_dst(msg_dst), .reply_valid(reply_valid),
    .reply_dst(reply_dst), .proto_err(proto_err), .busy(busy),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [17:0] exp_q[$];

  localparam int K_IGN = 0, K_ERR = 1, K_WB = 2, K_REPLY = 3, K_SEND = 4;

  // Model: block state 0 uncached, 1 shared, 2 exclusive; sharer set.
  logic [1:0] m_st [4];
  logic [3:0] m_sh [4];
  int         m_last;

  function automatic logic [17:0] vec(input logic [3:0] g, input logic mv,
                                      input logic [1:0] mt, input logic [3:0] md,
                                      input logic rv, input logic [3:0] rd,
                                      input logic pe, input logic b);
    return {g, mv, mt, md, rv, rd, pe, b};
  endfunction

  function automatic logic [17:0] obs();
    return {grant, msg_valid, msg_type, msg_dst, reply_valid, reply_dst,
            proto_err, busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic cyc(input string tag);
    logic [17:0] e;
    e = exp_q.pop_front();
    chk(tag, 32'(obs()), 32'(e));
  endtask

  task automatic model_reset();
    m_last = 3;
    for (int b = 0; b < 4; b++) begin
      m_st[b] = 2'd0;
      m_sh[b] = 4'd0;
    end
  endtask

  task automatic check_dir(input string tag);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("%s_st%0d", tag, b), 32'(dut.dir_st[b]), 32'(m_st[b]));
      chk($sformatf("%s_sh%0d", tag, b), 32'(dut.dir_sh[b]), 32'(m_sh[b]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a negedge (or at time 0).
  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    ack   = '0;
    #1;
    exp_q.push_back('0);
    cyc("rst_during");
    @(negedge clock);
    exp_q.push_back('0);
    cyc("rst_held");
    model_reset();
    check_dir("rst_dir");
    reset = 1'b0;
    @(negedge clock);
    exp_q.push_back('0);
    cyc("rst_after");
  endtask

  // One request from requester p while the arbiter is idle. With abort set,
  // a transaction that sends a message is left waiting for acks and reset.
  task automatic do_txn(input int p, input int op, input int blk, input bit abort);
    logic [3:0] pb, pend, rem, nz, sel;
    logic [1:0] nst;
    logic [3:0] nsh;
    int kind, mt, n, it;
    bit is_w, first, sent_first;
    pb   = 4'b0001 << p;
    nst  = m_st[blk];
    nsh  = m_sh[blk];
    pend = '0;
    mt   = 0;
    is_w = (op == 3);
    if (op == 1) begin
      kind = K_IGN;
    end else if (op == 2) begin
      if (m_st[blk] == 2'd2 && m_sh[blk] == pb) begin
        kind = K_WB;
        nst  = 2'd0;
        nsh  = 4'd0;
      end else begin
        kind = K_ERR;
      end
    end else if (m_st[blk] == 2'd2 && m_sh[blk] == pb) begin
      kind = K_REPLY;
    end else begin
      if (m_st[blk] == 2'd2) begin
        pend = m_sh[blk];
        mt   = is_w ? 3 : 2;
      end else if (m_st[blk] == 2'd1 && is_w) begin
        pend = m_sh[blk] & ~pb;
        mt   = 1;
      end
      kind = (pend != 4'd0) ? K_SEND : K_REPLY;
      if (is_w) begin
        nst = 2'd2;
        nsh = pb;
      end else begin
        nst = 2'd1;
        nsh = m_sh[blk] | pb;
      end
    end

    req[p] = 1'b1;
    req_op[2*p +: 2]  = 2'(op);
    req_blk[2*p +: 2] = 2'(blk);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (grant == 4'b0 && n < 20);
    chk("grant_latency", 32'(n), 32'd1);
    m_last = p;
    exp_q.push_back(vec(pb, 1'b0, 2'b0, 4'b0, 1'b0, 4'b0, kind == K_ERR, 1'b1));
    cyc("lookup");
    req[p] = 1'b0;

    if (kind == K_SEND) begin
      @(negedge clock);
      exp_q.push_back(vec(4'b0, 1'b1, 2'(mt), pend, 1'b0, 4'b0, 1'b0, 1'b1));
      cyc("send");
      if (abort) begin
        repeat (3) begin
          @(negedge clock);
          exp_q.push_back(vec(4'b0, 1'b0, 2'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b1));
          cyc("wait_hold");
        end
        apply_reset();
        return;
      end
      rem = pend;
      it = 0;
      first = 1'b1;
      sent_first = 1'b0;
      while (rem != 4'd0) begin
        // Noise acks go to processors that are not (or no longer) pending.
        nz = 4'($urandom_range(0, 15)) & ~rem;
        if ($urandom_range(0, 2) != 0 || it > 10) begin
          do sel = 4'b0001 << $urandom_range(0, 3); while ((sel & rem) == 4'd0);
          rem = rem & ~sel;
          ack = sel | nz;
        end else begin
          ack = nz;
        end
        it++;
        sent_first = first;
        first = 1'b0;
        @(negedge clock);
        ack = '0;
        // An ack taken in SEND still passes through one WAIT_ACK cycle.
        if (rem != 4'd0 || sent_first) begin
          exp_q.push_back(vec(4'b0, 1'b0, 2'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b1));
          cyc("wait_ack");
        end
      end
      if (sent_first) @(negedge clock);
      exp_q.push_back(vec(4'b0, 1'b0, 2'b0, 4'b0, 1'b1, pb, 1'b0, 1'b1));
      cyc("reply_after_ack");
      @(negedge clock);
      exp_q.push_back('0);
      cyc("idle");
    end else if (kind == K_REPLY) begin
      @(negedge clock);
      exp_q.push_back(vec(4'b0, 1'b0, 2'b0, 4'b0, 1'b1, pb, 1'b0, 1'b1));
      cyc("reply");
      @(negedge clock);
      exp_q.push_back('0);
      cyc("idle");
    end else begin
      @(negedge clock);
      exp_q.push_back('0);
      cyc("idle_noreply");
    end
    m_st[blk] = nst;
    m_sh[blk] = nsh;
    check_dir("dir");
  endtask

  // Several simultaneous read-hit requests; checks round-robin order.
  task automatic arb_round(input logic [3:0] mask, input bit hold, input int ngrants);
    logic [3:0] rem;
    int w, n;
    bit found;
    rem = mask;
    for (int i = 0; i < 4; i++) begin
      req_op[2*i +: 2]  = 2'b01;
      req_blk[2*i +: 2] = 2'($urandom_range(0, 3));
    end
    req = mask;
    for (int k = 0; k < ngrants; k++) begin
      found = 1'b0;
      w = 0;
      for (int d = 1; d <= 4; d++) begin
        if (!found && rem[(m_last + d) % 4]) begin
          found = 1'b1;
          w = (m_last + d) % 4;
        end
      end
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (grant == 4'b0 && n < 10);
      chk("rr_grant", 32'(grant), 32'(4'b0001 << w));
      m_last = w;
      if (!hold) begin
        rem[w] = 1'b0;
        req[w] = 1'b0;
      end
    end
    req = '0;
    @(negedge clock);
    exp_q.push_back('0);
    cyc("rr_idle");
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int p, op, blk;
    model_reset();
    apply_reset();

    // P0 read miss on blk0 from reset.
    do_txn(0, 0, 0, 1'b0);
    // Three readers of blk1, then P3 write miss invalidates 0111.
    do_txn(0, 0, 1, 1'b0);
    do_txn(1, 0, 1, 1'b0);
    do_txn(2, 0, 1, 1'b0);
    do_txn(3, 3, 1, 1'b0);
    // P2 owns blk2; P1 read miss fetches from P2.
    do_txn(2, 3, 2, 1'b0);
    do_txn(1, 0, 2, 1'b0);
    // Illegal writeback on uncached blk3, then a legal one from P3 on blk1.
    do_txn(1, 2, 3, 1'b0);
    do_txn(3, 2, 1, 1'b0);
    // Read hit is ignored; owner re-miss needs no message.
    do_txn(0, 1, 0, 1'b0);
    do_txn(2, 3, 3, 1'b0);
    do_txn(2, 0, 3, 1'b0);
    // Write miss on exclusive by another requester: fetch-invalidate.
    do_txn(0, 3, 3, 1'b0);

    // All four requesting continuously from reset.
    apply_reset();
    arb_round(4'hF, 1'b1, 5);

    for (int r = 0; r < 10; r++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      arb_round(m, 1'b0, $countones(m));
    end

    for (int t = 0; t < 150; t++) begin
      p   = $urandom_range(0, 3);
      op  = $urandom_range(0, 3);
      blk = $urandom_range(0, 3);
      if (op == 2 && $urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 4; b++) begin
          if (m_st[b] == 2'd2) begin
            blk = b;
            for (int i = 0; i < 4; i++) if (m_sh[b][i]) p = i;
          end
        end
      end
      do_txn(p, op, blk, 1'b0);
    end

    // Reset while waiting for acks aborts the transaction.
    apply_reset();
    do_txn(0, 0, 1, 1'b0);
    do_txn(1, 0, 1, 1'b0);
    do_txn(2, 3, 1, 1'b1);
    do_txn(0, 0, 0, 1'b0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
